// File: rtl/hazard_ctrl_pkg.sv
// Shared core encodings used by the hazard controller and its forwarding units.
package hazard_ctrl_pkg;

   // EX-stage result select; RESULT_SRC_MEM identifies a load in EX.
   typedef enum logic [1:0] {
      RESULT_SRC_ALU = 2'b00,
      RESULT_SRC_MEM = 2'b01,
      RESULT_SRC_PC4 = 2'b10
   } resultSrc_e;

   // EX operand source select.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwdSel_e;

   // Data-memory wait sequencer states.
   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } memState_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational forwarding compare for one EX source operand.
// A younger producer in MEM wins over an older one in WB; x0 never forwards.
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic       reg_wr_en_m,
   input  logic [4:0] rd_w,
   input  logic       reg_wr_en_w,
   output fwdSel_e    fwd_sel
);

   logic hit_m;
   logic hit_w;

   assign hit_m = reg_wr_en_m && (rd_m != 5'd0) && (rd_m == rs_e);
   assign hit_w = reg_wr_en_w && (rd_w != 5'd0) && (rd_w == rs_e);

   // Select the operand source, MEM before WB before the register file.
   always_comb begin
      fwd_sel = FWD_RF;
      if (hit_m)
         fwd_sel = FWD_MEM;
      else if (hit_w)
         fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage RV32 core:
// stall/flush enables, EX operand forwarding, data-memory wait FSM with a
// watchdog, and stall/flush performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  resultSrc_e       result_src_e,
   input  logic             pc_src_e,
   input  logic [4:0]       rd_m,
   input  logic             reg_wr_en_m,
   input  logic [4:0]       rd_w,
   input  logic             reg_wr_en_w,
   input  logic             dmem_req_m,
   input  logic             dmem_ready,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             stall_w,
   output logic             flush_d,
   output logic             flush_e,
   output logic [1:0]       fwd_a_e,
   output logic [1:0]       fwd_b_e,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Watchdog counter only needs to reach MEM_TIMEOUT; it then saturates.
   localparam int              WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   memState_e         state;
   memState_e         state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              timeout_hit;
   logic              mem_stall;
   logic              lwstall;
   logic              any_stall;
   fwdSel_e           fwd_a_sel;
   fwdSel_e           fwd_b_sel;

   // ------------------------------------------------------------------
   // Forwarding
   // ------------------------------------------------------------------
   fwd_unit u_fwd_a (
      .rs_e        (rs1_e),
      .rd_m        (rd_m),
      .reg_wr_en_m (reg_wr_en_m),
      .rd_w        (rd_w),
      .reg_wr_en_w (reg_wr_en_w),
      .fwd_sel     (fwd_a_sel)
   );

   fwd_unit u_fwd_b (
      .rs_e        (rs2_e),
      .rd_m        (rd_m),
      .reg_wr_en_m (reg_wr_en_m),
      .rd_w        (rd_w),
      .reg_wr_en_w (reg_wr_en_w),
      .fwd_sel     (fwd_b_sel)
   );

   assign fwd_a_e = fwd_a_sel;
   assign fwd_b_e = fwd_b_sel;

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   // A memory stall covers both a fresh request that is not ready and an
   // ongoing wait; a same-cycle completion never stalls.
   assign mem_stall = (dmem_req_m && !dmem_ready) ||
                      ((state == MEM_WAIT) && !dmem_ready);

   assign lwstall = (result_src_e == RESULT_SRC_MEM) && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

   // Stall/flush enables. A memory stall freezes the whole pipe and masks
   // both flushes; a taken branch held in EX by that freeze therefore
   // flushes in the first cycle the stall lifts.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (mem_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         stall_w = 1'b1;
      end else begin
         if (lwstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
         if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   assign any_stall = stall_f | stall_d | stall_e | stall_m | stall_w;

   // ------------------------------------------------------------------
   // Memory wait FSM
   // ------------------------------------------------------------------
   // Next-state: enter MEM_WAIT on an unready request, leave on ready.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (dmem_req_m && !dmem_ready) state_nxt = MEM_WAIT;
         MEM_WAIT: if (dmem_ready)                state_nxt = RUN;
         default:                                 state_nxt = RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_n)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------
   // Count unready MEM_WAIT cycles, saturating at MEM_TIMEOUT; any cycle
   // outside such a wait (including the release cycle) clears the count.
   always_comb begin
      wait_cnt_nxt = '0;
      if ((state == MEM_WAIT) && !dmem_ready)
         wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
   end

   assign timeout_hit = (MEM_TIMEOUT != 0) && (state == MEM_WAIT) &&
                        !dmem_ready && (wait_cnt_nxt == WAIT_MAX);

   // Wait counter and sticky timeout flag; only reset clears the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
         if (timeout_hit)
            mem_timeout_err <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   // Free-running, wrapping counts of stall cycles and EX flush cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (any_stall)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_e)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic, checked against a cycle-level behavioural model via a scoreboard.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int CNT_W       = 8;
   localparam int MEM_TIMEOUT = 4;

   typedef struct {
      logic       rst_n;
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      resultSrc_e src;
      logic       pc;
      logic [4:0] rd_m;
      logic       wm;
      logic [4:0] rd_w;
      logic       ww;
      logic       req;
      logic       rdy;
   } stim_t;

   typedef struct {
      logic [4:0]       stall;   // {f,d,e,m,w}
      logic [1:0]       flush;   // {d,e}
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic             err;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   resultSrc_e       result_src_e;
   logic             pc_src_e, reg_wr_en_m, reg_wr_en_w, dmem_req_m, dmem_ready;
   logic             stall_f, stall_d, stall_e, stall_m, stall_w;
   logic             flush_d, flush_e;
   logic [1:0]       fwd_a_e, fwd_b_e;
   logic             mem_timeout_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rs1_d           (rs1_d),
      .rs2_d           (rs2_d),
      .rs1_e           (rs1_e),
      .rs2_e           (rs2_e),
      .rd_e            (rd_e),
      .result_src_e    (result_src_e),
      .pc_src_e        (pc_src_e),
      .rd_m            (rd_m),
      .reg_wr_en_m     (reg_wr_en_m),
      .rd_w            (rd_w),
      .reg_wr_en_w     (reg_wr_en_w),
      .dmem_req_m      (dmem_req_m),
      .dmem_ready      (dmem_ready),
      .stall_f         (stall_f),
      .stall_d         (stall_d),
      .stall_e         (stall_e),
      .stall_m         (stall_m),
      .stall_w         (stall_w),
      .flush_d         (flush_d),
      .flush_e         (flush_e),
      .fwd_a_e         (fwd_a_e),
      .fwd_b_e         (fwd_b_e),
      .mem_timeout_err (mem_timeout_err),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   // Reference model state: is a memory access still outstanding from an
   // earlier cycle, how many unready cycles it has waited, and the counts.
   bit               m_outstanding;
   int               m_waited;
   bit               m_err;
   logic [CNT_W-1:0] m_sc;
   logic [CNT_W-1:0] m_fc;
   bit               m_last_frozen;
   stim_t            last_s;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
      if (s.wm && s.rd_m != 0 && s.rd_m == rs) return 2'b10;
      if (s.ww && s.rd_w != 0 && s.rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic stim_t idle(input logic rst);
      stim_t s;
      s.rst_n = rst;
      s.rs1_d = 0; s.rs2_d = 0; s.rs1_e = 0; s.rs2_e = 0; s.rd_e = 0;
      s.src = RESULT_SRC_ALU; s.pc = 0;
      s.rd_m = 0; s.wm = 0; s.rd_w = 0; s.ww = 0;
      s.req = 0; s.rdy = 0;
      return s;
   endfunction

   // One clock cycle: apply inputs away from the edge, predict, enqueue.
   task automatic run_cycle(input stim_t s);
      exp_t e;
      bit   frozen, lw, fl_e, fl_d;
      @(posedge clk);
      #1;
      rst_n        = s.rst_n;
      rs1_d        = s.rs1_d;  rs2_d = s.rs2_d;
      rs1_e        = s.rs1_e;  rs2_e = s.rs2_e;  rd_e = s.rd_e;
      result_src_e = s.src;    pc_src_e = s.pc;
      rd_m         = s.rd_m;   reg_wr_en_m = s.wm;
      rd_w         = s.rd_w;   reg_wr_en_w = s.ww;
      dmem_req_m   = s.req;    dmem_ready  = s.rdy;

      if (!s.rst_n) begin
         m_outstanding = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
      end

      frozen = !s.rdy && (s.req || m_outstanding);
      lw     = (s.src == RESULT_SRC_MEM) && s.rd_e != 0 &&
               (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
      fl_d   = !frozen && s.pc;
      fl_e   = !frozen && (s.pc || lw);

      e.stall = frozen ? 5'b11111 : (lw ? 5'b11000 : 5'b00000);
      e.flush = {fl_d, fl_e};
      e.fa    = fwd_ref(s.rs1_e, s);
      e.fb    = fwd_ref(s.rs2_e, s);
      e.err   = m_err;
      e.sc    = m_sc;
      e.fc    = m_fc;
      sb_q.push_back(e);

      if (s.rst_n) begin
         if (e.stall != 0) m_sc = m_sc + 1'b1;
         if (fl_e)         m_fc = m_fc + 1'b1;
         if (m_outstanding && !s.rdy) begin
            if (m_waited < MEM_TIMEOUT) m_waited++;
            if (MEM_TIMEOUT != 0 && m_waited == MEM_TIMEOUT) m_err = 1;
         end else begin
            m_waited = 0;
         end
         m_outstanding = frozen;
      end
      m_last_frozen = frozen;
      last_s        = s;
   endtask

   // Monitor: the DUT presents a fresh response every cycle; compare it
   // mid-cycle against the oldest prediction.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("stall", {27'd0, stall_f, stall_d, stall_e, stall_m, stall_w}, {27'd0, e.stall});
         check("flush", {30'd0, flush_d, flush_e}, {30'd0, e.flush});
         check("fwd_a", {30'd0, fwd_a_e}, {30'd0, e.fa});
         check("fwd_b", {30'd0, fwd_b_e}, {30'd0, e.fb});
         check("timeout_err", {31'd0, mem_timeout_err}, {31'd0, e.err});
         check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
         check("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded its time budget");
      $fatal(1, "time budget exceeded");
   end

   initial begin
      stim_t s;
      s = idle(1'b0);
      rst_n = 0;
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
      result_src_e = RESULT_SRC_ALU; pc_src_e = 0;
      rd_m = 0; reg_wr_en_m = 0; rd_w = 0; reg_wr_en_w = 0;
      dmem_req_m = 0; dmem_ready = 0;
      m_outstanding = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
      m_last_frozen = 0; last_s = s;

      // Reset state
      run_cycle(idle(1'b0));
      run_cycle(idle(1'b0));
      run_cycle(idle(1'b1));

      // 1. Forwarding priority: MEM over WB, then WB when rd_m is x0
      s = idle(1'b1);
      s.wm = 1; s.rd_m = 5; s.ww = 1; s.rd_w = 5; s.rs1_e = 5; s.rs2_e = 5;
      run_cycle(s);
      s.rd_m = 0;
      run_cycle(s);
      s.rs2_e = 6; s.rd_m = 6;
      run_cycle(s);

      // 2. Load-use, then the same with rd_e = x0
      s = idle(1'b1);
      s.src = RESULT_SRC_MEM; s.rd_e = 7; s.rs2_d = 7;
      run_cycle(s);
      s.rd_e = 0;
      run_cycle(s);

      // 3. Taken branch
      s = idle(1'b1);
      s.pc = 1;
      run_cycle(s);
      run_cycle(idle(1'b1));

      // 4. Three-cycle memory wait with a taken branch held in EX
      s = idle(1'b1);
      s.req = 1; s.pc = 1;
      for (int i = 0; i < 3; i++) run_cycle(s);
      s.rdy = 1;
      run_cycle(s);
      run_cycle(idle(1'b1));

      // 5. Watchdog, then a reset pulse in the middle of a wait
      s = idle(1'b1);
      s.req = 1;
      for (int i = 0; i < 10; i++) run_cycle(s);
      s.rdy = 1;
      run_cycle(s);
      run_cycle(idle(1'b1));
      s.rdy = 0;
      for (int i = 0; i < 3; i++) run_cycle(s);
      s.rst_n = 0;
      run_cycle(s);
      s.rst_n = 1; s.req = 0;
      run_cycle(s);

      // 6. Zero-latency memory
      s = idle(1'b1);
      s.req = 1; s.rdy = 1;
      for (int i = 0; i < 5; i++) run_cycle(s);

      // Randomized traffic; the pipeline inputs are held while frozen.
      for (int n = 0; n < 2500; n++) begin
         if (m_last_frozen) begin
            s = last_s;
         end else begin
            s.rs1_d = 5'($urandom_range(0, 3));
            s.rs2_d = 5'($urandom_range(0, 3));
            s.rs1_e = 5'($urandom_range(0, 3));
            s.rs2_e = 5'($urandom_range(0, 3));
            s.rd_e  = 5'($urandom_range(0, 3));
            s.rd_m  = 5'($urandom_range(0, 3));
            s.rd_w  = 5'($urandom_range(0, 3));
            s.wm    = 1'($urandom_range(0, 1));
            s.ww    = 1'($urandom_range(0, 1));
            s.src   = resultSrc_e'(2'($urandom_range(0, 2)));
            s.pc    = (s.src == RESULT_SRC_MEM) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
            s.req   = 1'($urandom_range(0, 2) == 0);
         end
         s.rdy   = 1'($urandom_range(0, 2) == 0);
         s.rst_n = ($urandom_range(0, 199) != 0);
         run_cycle(s);
      end

      // Drain the scoreboard with a bounded wait.
      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32 core.
- Drives stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and operand-forwarding selects for EX.
- Runs a data-memory wait FSM with a watchdog, plus stall/flush performance counters.
- Sits beside the datapath and takes stage register indices and control signals from each pipeline register output.

Parameters:
- CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_timeout_err sets. 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs1_d, rs2_d  in  5 each  source registers in ID
- rs1_e, rs2_e, rd_e  in  5 each  source and destination registers in EX
- result_src_e  in  resultSrc_e  EX result select; RESULT_SRC_MEM marks a load
- pc_src_e  in  1  taken branch/jump resolved in EX
- rd_m  in  5  MEM destination register
- reg_wr_en_m  in  1  MEM register write enable
- rd_w  in  5  WB destination register
- reg_wr_en_w  in  1  WB register write enable
- dmem_req_m  in  1  load/store present in MEM
- dmem_ready  in  1  data memory completes the request this cycle
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM / MEM-WB
- flush_d, flush_e  out  1 each  bubble IF-ID / ID-EX
- fwd_a_e, fwd_b_e  out  2 each  EX operand select: 00 regfile, 01 WB result, 10 MEM alu_result
- mem_timeout_err  out  1  sticky watchdog error
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
Reset:
- Asynchronous reset when rst_n is low.
- state=RUN; wait_cnt=0; mem_timeout_err=0; stall_cnt=0; flush_cnt=0.
- Combinational outputs follow their inputs at all times, including during reset.

Forwarding (combinational):
- fwd_a_e=10 if reg_wr_en_m & rd_m!=0 & rd_m==rs1_e.
- Else fwd_a_e=01 if reg_wr_en_w & rd_w!=0 & rd_w==rs1_e.
- Else fwd_a_e=00.
- MEM has priority over WB. fwd_b_e is identical using rs2_e.

Memory wait:
- mem_stall = dmem_req_m & ~dmem_ready, or state==MEM_WAIT & ~dmem_ready.
- While mem_stall: all of stall_f..stall_w=1, flush_d=0, flush_e=0. The whole pipe freezes.
- Holding MEM/WB repeats an idempotent regfile write, and the WB forwarding source stays valid.

Load-use (only when !mem_stall):
- lwstall = (result_src_e==RESULT_SRC_MEM) & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- Effect: stall_f=stall_d=1, flush_e=1.

Branch (only when !mem_stall):
- pc_src_e -> flush_d=1, flush_e=1.
- lwstall and pc_src_e are mutually exclusive: one EX instruction cannot be both a load and a branch.

Deferred flush:
- A taken branch in EX during mem_stall stays pending, because ID/EX is held.
- Its flush asserts in the first cycle mem_stall deasserts.

FSM:
- RUN -> MEM_WAIT when dmem_req_m & ~dmem_ready.
- MEM_WAIT -> RUN when dmem_ready. The release cycle has stalls=0.
- A request completing in the same cycle it appears (dmem_ready=1) never leaves RUN and costs 0 stall cycles.

Watchdog:
- wait_cnt increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
- When wait_cnt reaches MEM_TIMEOUT (MEM_TIMEOUT!=0), mem_timeout_err sets and holds until reset.
- The pipeline remains stalled; dmem_ready still releases it.
- wait_cnt saturates.

Counters:
- stall_cnt +1 every cycle any stall_* is 1.
- flush_cnt +1 every cycle flush_e is 1.
- Both wrap modulo 2^CNT_W.

Reset mid-wait:
- Returns to RUN immediately; the counters and error clear.

Decomposition:
- resultSrc_e (including RESULT_SRC_MEM and RESULT_SRC_ALU) and the fwdSel_e encodings (FWD_RF, FWD_WB, FWD_MEM) belong in the shared core package.
- memState_e {RUN, MEM_WAIT} goes in the same package.
- One sub-module, fwd_unit, holds the combinational forwarding compare and is instantiated twice (operands A and B).
- FSM, stall/flush logic and counters stay in hazard_ctrl.

Test Plan:
1. MEM hazard: reg_wr_en_m=1, rd_m=5, rs1_e=5; WB also writes x5 -> fwd_a_e=10. With rd_m=0 instead -> WB match -> fwd_a_e=01.
2. Load-use: result_src_e=MEM, rd_e=7, rs2_d=7, no mem request -> stall_f=stall_d=flush_e=1 for 1 cycle; stall_cnt +1, flush_cnt +1. With rd_e=0 -> no stall.
3. Taken branch: pc_src_e=1 -> flush_d=flush_e=1, no stalls, flush_cnt +1.
4. Mem wait: dmem_req_m=1, dmem_ready low for 3 cycles then high -> all stalls=1 for exactly 3 cycles, state returns to RUN, stall_cnt=3. pc_src_e held high throughout -> flush_d/flush_e=0 during wait, 1 on the release cycle.
5. Watchdog: MEM_TIMEOUT=4, dmem_ready held low 10 cycles -> mem_timeout_err rises after the 4th wait cycle and stays 1 after dmem_ready. Pulsing rst_n low clears it and the counters asynchronously.
6. Zero-latency memory: dmem_req_m=1 with dmem_ready=1 every cycle -> no stalls, state stays RUN.
